// File: rtl/inst_tlb_responder.sv
// inst_tlb_responder
//   Joint TLB array for the instruction-fetch MMU, with the CP0 TLB
//   instruction paths (TLBWI/TLBWR write, TLBP probe, TLBR read).
//   The lookup, probe and read results are registered one cycle after
//   their strobe. The module also owns the Random counter for TLBWR.
//
// Build option: define TLB_RANDOM_EN to include the Random down-counter
//   and the Wired register. Without it, random_o is fixed at TLBNUM-1,
//   so TLBWR always writes the last entry, and wired_we_i/wired_i are
//   ignored.
//
// Ports
//   clk, rst                  clock, async active-low reset
//   inst_*                    IF lookup: strobe, vpn2/odd/asid key in;
//                             hit/index/pfn/c/d/v out
//   w_*                       entry write (w_random_i selects Random)
//   p_req_i, p_*_o            probe keyed by w_vpn2_i/w_asid_i
//   r_req_i, r_index_i, r_*_o entry read
//   wired_we_i, wired_i       Wired register write
//   random_o                  current Random value
module inst_tlb_responder #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_tlbReq_i,
  input  logic [18:0]      inst_vpn2_i,
  input  logic             inst_oddPage_i,
  input  logic [7:0]       inst_asid_i,
  output logic             inst_hit_o,
  output logic [IDX_W-1:0] inst_index_o,
  output logic [19:0]      inst_pfn_o,
  output logic [2:0]       inst_c_o,
  output logic             inst_d_o,
  output logic             inst_v_o,
  input  logic             w_en_i,
  input  logic             w_random_i,
  input  logic [IDX_W-1:0] w_index_i,
  input  logic [18:0]      w_vpn2_i,
  input  logic [7:0]       w_asid_i,
  input  logic             w_g_i,
  input  logic [19:0]      w_pfn0_i,
  input  logic [19:0]      w_pfn1_i,
  input  logic [2:0]       w_c0_i,
  input  logic [2:0]       w_c1_i,
  input  logic             w_d0_i,
  input  logic             w_d1_i,
  input  logic             w_v0_i,
  input  logic             w_v1_i,
  input  logic             p_req_i,
  output logic             p_done_o,
  output logic             p_hit_o,
  output logic [IDX_W-1:0] p_index_o,
  input  logic             r_req_i,
  input  logic [IDX_W-1:0] r_index_i,
  output logic             r_done_o,
  output logic [18:0]      r_vpn2_o,
  output logic [7:0]       r_asid_o,
  output logic             r_g_o,
  output logic [19:0]      r_pfn0_o,
  output logic [19:0]      r_pfn1_o,
  output logic [2:0]       r_c0_o,
  output logic [2:0]       r_c1_o,
  output logic             r_d0_o,
  output logic             r_d1_o,
  output logic             r_v0_o,
  output logic             r_v1_o,
  input  logic             wired_we_i,
  input  logic [IDX_W-1:0] wired_i,
  output logic [IDX_W-1:0] random_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  logic [18:0] e_vpn2 [TLBNUM];
  logic [7:0]  e_asid [TLBNUM];
  logic        e_g    [TLBNUM];
  logic [19:0] e_pfn0 [TLBNUM];
  logic [19:0] e_pfn1 [TLBNUM];
  logic [2:0]  e_c0   [TLBNUM];
  logic [2:0]  e_c1   [TLBNUM];
  logic        e_d0   [TLBNUM];
  logic        e_d1   [TLBNUM];
  logic        e_v0   [TLBNUM];
  logic        e_v1   [TLBNUM];

  logic             l_hit, q_hit;
  logic [IDX_W-1:0] l_idx, q_idx;
  logic [IDX_W-1:0] w_idx;

  // Scan from the top down so that, with duplicate entries, the lowest
  // matching index is the one left standing.
  always_comb begin
    l_hit = 1'b0;
    l_idx = '0;
    q_hit = 1'b0;
    q_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (e_vpn2[i] == inst_vpn2_i && (e_g[i] || e_asid[i] == inst_asid_i)) begin
        l_hit = 1'b1;
        l_idx = IDX_W'(i);
      end
      if (e_vpn2[i] == w_vpn2_i && (e_g[i] || e_asid[i] == w_asid_i)) begin
        q_hit = 1'b1;
        q_idx = IDX_W'(i);
      end
    end
  end

  assign w_idx = w_random_i ? random_o : w_index_i;

  // Array update. All lookups read the pre-edge contents, so a write and a
  // lookup to the same entry in one cycle return the old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TLBNUM; i++) begin
        e_vpn2[i] <= '0;
        e_asid[i] <= '0;
        e_g[i]    <= 1'b0;
        e_pfn0[i] <= '0;
        e_pfn1[i] <= '0;
        e_c0[i]   <= '0;
        e_c1[i]   <= '0;
        e_d0[i]   <= 1'b0;
        e_d1[i]   <= 1'b0;
        e_v0[i]   <= 1'b0;
        e_v1[i]   <= 1'b0;
      end
    end else if (w_en_i) begin
      e_vpn2[w_idx] <= w_vpn2_i;
      e_asid[w_idx] <= w_asid_i;
      e_g[w_idx]    <= w_g_i;
      e_pfn0[w_idx] <= w_pfn0_i;
      e_pfn1[w_idx] <= w_pfn1_i;
      e_c0[w_idx]   <= w_c0_i;
      e_c1[w_idx]   <= w_c1_i;
      e_d0[w_idx]   <= w_d0_i;
      e_d1[w_idx]   <= w_d1_i;
      e_v0[w_idx]   <= w_v0_i;
      e_v1[w_idx]   <= w_v1_i;
    end
  end

  // Lookup, probe and read result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_hit_o   <= 1'b0;
      inst_index_o <= '0;
      inst_pfn_o   <= '0;
      inst_c_o     <= '0;
      inst_d_o     <= 1'b0;
      inst_v_o     <= 1'b0;
      p_done_o     <= 1'b0;
      p_hit_o      <= 1'b0;
      p_index_o    <= '0;
      r_done_o     <= 1'b0;
      r_vpn2_o     <= '0;
      r_asid_o     <= '0;
      r_g_o        <= 1'b0;
      r_pfn0_o     <= '0;
      r_pfn1_o     <= '0;
      r_c0_o       <= '0;
      r_c1_o       <= '0;
      r_d0_o       <= 1'b0;
      r_d1_o       <= 1'b0;
      r_v0_o       <= 1'b0;
      r_v1_o       <= 1'b0;
    end else begin
      if (inst_tlbReq_i) begin
        inst_hit_o   <= l_hit;
        inst_index_o <= l_idx;
        if (!l_hit) begin
          inst_pfn_o <= '0;
          inst_c_o   <= '0;
          inst_d_o   <= 1'b0;
          inst_v_o   <= 1'b0;
        end else if (inst_oddPage_i) begin
          inst_pfn_o <= e_pfn1[l_idx];
          inst_c_o   <= e_c1[l_idx];
          inst_d_o   <= e_d1[l_idx];
          inst_v_o   <= e_v1[l_idx];
        end else begin
          inst_pfn_o <= e_pfn0[l_idx];
          inst_c_o   <= e_c0[l_idx];
          inst_d_o   <= e_d0[l_idx];
          inst_v_o   <= e_v0[l_idx];
        end
      end
      p_done_o <= p_req_i;
      if (p_req_i) begin
        p_hit_o   <= q_hit;
        p_index_o <= q_idx;
      end
      r_done_o <= r_req_i;
      if (r_req_i) begin
        r_vpn2_o <= e_vpn2[r_index_i];
        r_asid_o <= e_asid[r_index_i];
        r_g_o    <= e_g[r_index_i];
        r_pfn0_o <= e_pfn0[r_index_i];
        r_pfn1_o <= e_pfn1[r_index_i];
        r_c0_o   <= e_c0[r_index_i];
        r_c1_o   <= e_c1[r_index_i];
        r_d0_o   <= e_d0[r_index_i];
        r_d1_o   <= e_d1[r_index_i];
        r_v0_o   <= e_v0[r_index_i];
        r_v1_o   <= e_v1[r_index_i];
      end
    end
  end

`ifdef TLB_RANDOM_EN
  logic [IDX_W-1:0] random_q;
  logic [IDX_W-1:0] wired_q;

  // Random runs from TLBNUM-1 down to Wired, then wraps; "<=" also covers
  // a Wired at or above TLBNUM-1, which pins Random at the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      random_q <= LAST_IDX;
      wired_q  <= '0;
    end else if (wired_we_i) begin
      wired_q  <= wired_i;
      random_q <= LAST_IDX;
    end else if (random_q <= wired_q) begin
      random_q <= LAST_IDX;
    end else begin
      random_q <= random_q - 1'b1;
    end
  end

  assign random_o = random_q;
`else
  logic unused_wired;
  assign unused_wired = ^{wired_we_i, wired_i};
  assign random_o     = LAST_IDX;
`endif

endmodule

// File: tb/tb_inst_tlb_responder.sv
module tb_inst_tlb_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_tlbReq_i = 1'b0;
  logic [18:0] inst_vpn2_i = '0;
  logic        inst_oddPage_i = 1'b0;
  logic [7:0]  inst_asid_i = '0;
  logic        inst_hit_o;
  logic [3:0]  inst_index_o;
  logic [19:0] inst_pfn_o;
  logic [2:0]  inst_c_o;
  logic        inst_d_o, inst_v_o;
  logic        w_en_i = 1'b0, w_random_i = 1'b0;
  logic [3:0]  w_index_i = '0;
  logic [18:0] w_vpn2_i = '0;
  logic [7:0]  w_asid_i = '0;
  logic        w_g_i = 1'b0;
  logic [19:0] w_pfn0_i = '0, w_pfn1_i = '0;
  logic [2:0]  w_c0_i = '0, w_c1_i = '0;
  logic        w_d0_i = 1'b0, w_d1_i = 1'b0, w_v0_i = 1'b0, w_v1_i = 1'b0;
  logic        p_req_i = 1'b0;
  logic        p_done_o, p_hit_o;
  logic [3:0]  p_index_o;
  logic        r_req_i = 1'b0;
  logic [3:0]  r_index_i = '0;
  logic        r_done_o;
  logic [18:0] r_vpn2_o;
  logic [7:0]  r_asid_o;
  logic        r_g_o;
  logic [19:0] r_pfn0_o, r_pfn1_o;
  logic [2:0]  r_c0_o, r_c1_o;
  logic        r_d0_o, r_d1_o, r_v0_o, r_v1_o;
  logic        wired_we_i = 1'b0;
  logic [3:0]  wired_i = '0;
  logic [3:0]  random_o;

  int n_pass = 0;
  int n_total = 0;

  inst_tlb_responder #(.TLBNUM(16)) dut (
    .clk(clk), .rst(rst),
    .inst_tlbReq_i(inst_tlbReq_i), .inst_vpn2_i(inst_vpn2_i),
    .inst_oddPage_i(inst_oddPage_i), .inst_asid_i(inst_asid_i),
    .inst_hit_o(inst_hit_o), .inst_index_o(inst_index_o), .inst_pfn_o(inst_pfn_o),
    .inst_c_o(inst_c_o), .inst_d_o(inst_d_o), .inst_v_o(inst_v_o),
    .w_en_i(w_en_i), .w_random_i(w_random_i), .w_index_i(w_index_i),
    .w_vpn2_i(w_vpn2_i), .w_asid_i(w_asid_i), .w_g_i(w_g_i),
    .w_pfn0_i(w_pfn0_i), .w_pfn1_i(w_pfn1_i), .w_c0_i(w_c0_i), .w_c1_i(w_c1_i),
    .w_d0_i(w_d0_i), .w_d1_i(w_d1_i), .w_v0_i(w_v0_i), .w_v1_i(w_v1_i),
    .p_req_i(p_req_i), .p_done_o(p_done_o), .p_hit_o(p_hit_o), .p_index_o(p_index_o),
    .r_req_i(r_req_i), .r_index_i(r_index_i), .r_done_o(r_done_o),
    .r_vpn2_o(r_vpn2_o), .r_asid_o(r_asid_o), .r_g_o(r_g_o),
    .r_pfn0_o(r_pfn0_o), .r_pfn1_o(r_pfn1_o), .r_c0_o(r_c0_o), .r_c1_o(r_c1_o),
    .r_d0_o(r_d0_o), .r_d1_o(r_d1_o), .r_v0_o(r_v0_o), .r_v1_o(r_v1_o),
    .wired_we_i(wired_we_i), .wired_i(wired_i), .random_o(random_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
    logic        hit;
    logic [3:0]  idx;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } lk_vec_t;

  lk_vec_t vecs[6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic setw(input logic rnd, input logic [3:0] idx, input logic [18:0] vpn2,
                      input logic [7:0] asid, input logic g, input logic [19:0] p0,
                      input logic [19:0] p1, input logic [2:0] c0, input logic [2:0] c1,
                      input logic d0, input logic d1, input logic v0, input logic v1);
    w_en_i = 1'b1; w_random_i = rnd; w_index_i = idx;
    w_vpn2_i = vpn2; w_asid_i = asid; w_g_i = g;
    w_pfn0_i = p0; w_pfn1_i = p1; w_c0_i = c0; w_c1_i = c1;
    w_d0_i = d0; w_d1_i = d1; w_v0_i = v0; w_v1_i = v1;
  endtask

  task automatic wr(input logic rnd, input logic [3:0] idx, input logic [18:0] vpn2,
                    input logic [7:0] asid, input logic g, input logic [19:0] p0,
                    input logic [19:0] p1, input logic [2:0] c0, input logic [2:0] c1,
                    input logic d0, input logic d1, input logic v0, input logic v1);
    setw(rnd, idx, vpn2, asid, g, p0, p1, c0, c1, d0, d1, v0, v1);
    cyc();
    w_en_i = 1'b0; w_random_i = 1'b0;
  endtask

  task automatic lookup(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    inst_tlbReq_i = 1'b1; inst_vpn2_i = vpn2; inst_oddPage_i = odd; inst_asid_i = asid;
    cyc();
    inst_tlbReq_i = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_r1, exp_r2, exp_wr_idx;
`ifdef TLB_RANDOM_EN
    exp_r1 = 4'd14; exp_r2 = 4'd13; exp_wr_idx = 4'd13;
`else
    exp_r1 = 4'd15; exp_r2 = 4'd15; exp_wr_idx = 4'd15;
`endif

    vecs[0] = '{19'h12345, 1'b1, 8'h05, 1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1};
    vecs[1] = '{19'h12345, 1'b0, 8'h05, 1'b1, 4'd3, 20'h22222, 3'd2, 1'b0, 1'b1};
    vecs[2] = '{19'h12345, 1'b1, 8'h06, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};
    vecs[3] = '{19'h0ABCD, 1'b0, 8'h06, 1'b1, 4'd5, 20'h55555, 3'd4, 1'b1, 1'b1};
    vecs[4] = '{19'h0ABCD, 1'b1, 8'h77, 1'b1, 4'd5, 20'h66666, 3'd1, 1'b0, 1'b0};
    vecs[5] = '{19'h0ABCE, 1'b0, 8'h09, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};

    // Reset state
    cyc(); cyc();
    chk("rst_hit", {31'd0, inst_hit_o}, 32'd0);
    chk("rst_pfn", {12'd0, inst_pfn_o}, 32'd0);
    chk("rst_pdone", {31'd0, p_done_o}, 32'd0);
    chk("rst_rdone", {31'd0, r_done_o}, 32'd0);
    chk("rst_random", {28'd0, random_o}, 32'd15);
    rst = 1'b1;
    cyc();
    chk("random_step1", {28'd0, random_o}, {28'd0, exp_r1});
    cyc();
    chk("random_step2", {28'd0, random_o}, {28'd0, exp_r2});

    // Lookup on an empty TLB misses
    lookup(19'h00001, 1'b0, 8'h00);
    chk("empty_hit", {31'd0, inst_hit_o}, 32'd0);
    chk("empty_pfn", {12'd0, inst_pfn_o}, 32'd0);
    chk("empty_idx", {28'd0, inst_index_o}, 32'd0);

    wr(1'b0, 4'd3, 19'h12345, 8'h05, 1'b0, 20'h22222, 20'hABCDE, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    wr(1'b0, 4'd5, 19'h0ABCD, 8'h09, 1'b1, 20'h55555, 20'h66666, 3'd4, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back table lookups
    for (int i = 0; i < 6; i++) begin
      inst_tlbReq_i = 1'b1;
      inst_vpn2_i = vecs[i].vpn2; inst_oddPage_i = vecs[i].odd; inst_asid_i = vecs[i].asid;
      cyc();
      chk($sformatf("vec%0d_hit", i), {31'd0, inst_hit_o}, {31'd0, vecs[i].hit});
      chk($sformatf("vec%0d_idx", i), {28'd0, inst_index_o}, {28'd0, vecs[i].idx});
      chk($sformatf("vec%0d_pfn", i), {12'd0, inst_pfn_o}, {12'd0, vecs[i].pfn});
      chk($sformatf("vec%0d_cdv", i), {27'd0, inst_c_o, inst_d_o, inst_v_o},
          {27'd0, vecs[i].c, vecs[i].d, vecs[i].v});
    end
    inst_tlbReq_i = 1'b0;

    // Outputs hold while the strobe is low
    inst_vpn2_i = 19'h12345; inst_oddPage_i = 1'b1; inst_asid_i = 8'h05;
    cyc();
    chk("hold_hit", {31'd0, inst_hit_o}, 32'd0);
    lookup(19'h12345, 1'b1, 8'h05);
    inst_vpn2_i = 19'h00000;
    cyc();
    chk("hold_pfn", {12'd0, inst_pfn_o}, 32'hABCDE);

    // Global bit makes the ASID irrelevant
    wr(1'b0, 4'd3, 19'h12345, 8'h05, 1'b1, 20'h22222, 20'hABCDE, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    lookup(19'h12345, 1'b1, 8'h06);
    chk("global_hit", {31'd0, inst_hit_o}, 32'd1);
    chk("global_idx", {28'd0, inst_index_o}, 32'd3);

    // Write and lookup of the same entry in one cycle: old data first
    setw(1'b0, 4'd3, 19'h12345, 8'h05, 1'b1, 20'h22222, 20'h11111, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    inst_tlbReq_i = 1'b1; inst_vpn2_i = 19'h12345; inst_oddPage_i = 1'b1; inst_asid_i = 8'h05;
    cyc();
    w_en_i = 1'b0;
    chk("wr_same_old", {12'd0, inst_pfn_o}, 32'hABCDE);
    cyc();
    inst_tlbReq_i = 1'b0;
    chk("wr_same_new", {12'd0, inst_pfn_o}, 32'h11111);

    // Probe with duplicates at 7 and 2: lowest index wins
    wr(1'b0, 4'd7, 19'h2AAAA, 8'h33, 1'b0, 20'h0F0F0, 20'h12121, 3'd5, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    wr(1'b0, 4'd2, 19'h2AAAA, 8'h33, 1'b0, 20'h00002, 20'h00003, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    p_req_i = 1'b1; w_vpn2_i = 19'h2AAAA; w_asid_i = 8'h33;
    cyc();
    chk("probe_done", {31'd0, p_done_o}, 32'd1);
    chk("probe_hit", {31'd0, p_hit_o}, 32'd1);
    chk("probe_idx", {28'd0, p_index_o}, 32'd2);
    w_asid_i = 8'h34;
    cyc();
    p_req_i = 1'b0;
    chk("probe_miss_done", {31'd0, p_done_o}, 32'd1);
    chk("probe_miss", {27'd0, p_hit_o, p_index_o}, 32'd0);
    cyc();
    chk("probe_pulse_end", {31'd0, p_done_o}, 32'd0);

    // Read entry 7
    r_req_i = 1'b1; r_index_i = 4'd7;
    cyc();
    r_req_i = 1'b0; r_index_i = 4'd2;
    chk("read_done", {31'd0, r_done_o}, 32'd1);
    chk("read_vpn2", {13'd0, r_vpn2_o}, 32'h2AAAA);
    chk("read_asid_g", {23'd0, r_asid_o, r_g_o}, {23'd0, 8'h33, 1'b0});
    chk("read_pfn0", {12'd0, r_pfn0_o}, 32'h0F0F0);
    chk("read_pfn1", {12'd0, r_pfn1_o}, 32'h12121);
    chk("read_flags", {22'd0, r_c0_o, r_c1_o, r_d0_o, r_d1_o, r_v0_o, r_v1_o},
        {22'd0, 3'd5, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1});
    cyc();
    chk("read_pulse_end", {31'd0, r_done_o}, 32'd0);
    chk("read_hold", {12'd0, r_pfn0_o}, 32'h0F0F0);

    // Wired write and TLBWR at Random
    wired_we_i = 1'b1; wired_i = 4'd12;
    cyc();
    wired_we_i = 1'b0;
    chk("wired_r15", {28'd0, random_o}, 32'd15);
    cyc();
    chk("wired_r14", {28'd0, random_o}, {28'd0, exp_r1});
    cyc();
    chk("wired_r13", {28'd0, random_o}, {28'd0, exp_r2});
    wr(1'b1, 4'd0, 19'h3C3C3, 8'h01, 1'b0, 20'h0AAAA, 20'h0BBBB, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef TLB_RANDOM_EN
    chk("wired_r12", {28'd0, random_o}, 32'd12);
    cyc();
    chk("wired_wrap", {28'd0, random_o}, 32'd15);
`else
    chk("fixed_random", {28'd0, random_o}, 32'd15);
`endif
    lookup(19'h3C3C3, 1'b0, 8'h01);
    chk("tlbwr_hit", {31'd0, inst_hit_o}, 32'd1);
    chk("tlbwr_idx", {28'd0, inst_index_o}, {28'd0, exp_wr_idx});

    // Reset lands before a pending probe and write can take effect
    p_req_i = 1'b1; w_vpn2_i = 19'h2AAAA; w_asid_i = 8'h33;
    setw(1'b0, 4'd4, 19'h04444, 8'h01, 1'b1, 20'h44444, 20'h44444, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    cyc();
    chk("rstmid_pdone", {31'd0, p_done_o}, 32'd0);
    chk("rstmid_random", {28'd0, random_o}, 32'd15);
    chk("rstmid_hit", {31'd0, inst_hit_o}, 32'd0);
    p_req_i = 1'b0; w_en_i = 1'b0;
    cyc();
    chk("rstmid_pdone2", {31'd0, p_done_o}, 32'd0);
    rst = 1'b1;
    lookup(19'h2AAAA, 1'b0, 8'h33);
    chk("rstmid_cleared", {31'd0, inst_hit_o}, 32'd0);
    lookup(19'h04444, 1'b0, 8'h01);
    chk("rstmid_nowrite", {31'd0, inst_hit_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_tlb_responder.md
# inst_tlb_responder

Joint TLB array that answers the instruction-fetch MMU's lookup requests and services CP0 TLB instructions (TLBWI, TLBWR, TLBP, TLBR). Sits between the IF-stage memory-management unit and CP0. Lookup results are registered and returned one cycle after the request, aligned with the MMU's registered segment decode. It also owns the Random counter used by TLBWR.

## Interface
- TLBNUM, 16: number of entries; power of two, 4..32.
- IDX_W, $clog2(TLBNUM): index width, equal to `TLB_WIDTH.
---
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- inst_tlbReq_i  in  1  lookup strobe from MMU
- inst_vpn2_i  in  19  VA[31:13]
- inst_oddPage_i  in  1  VA[12]
- inst_asid_i  in  8  current ASID
- inst_hit_o  out  1  match found
- inst_index_o  out  IDX_W  matching entry
- inst_pfn_o  out  20  PFN of selected page (`CACHE_TAG)
- inst_c_o  out  3  cache attribute
- inst_d_o, inst_v_o  out  1 each  dirty / valid of selected page
- w_en_i  in  1  write strobe (TLBWI/TLBWR)
- w_random_i  in  1  1 = write at Random (TLBWR), 0 = at w_index_i
- w_index_i  in  IDX_W  TLBWI index
- w_vpn2_i 19, w_asid_i 8, w_g_i 1, w_pfn0_i/w_pfn1_i 20, w_c0_i/w_c1_i 3, w_d0_i/w_d1_i/w_v0_i/w_v1_i 1  in  entry contents
- p_req_i  in  1  TLBP strobe; uses w_vpn2_i, w_asid_i as key
- p_done_o  out  1  one-cycle pulse, probe result valid
- p_hit_o  out  1  probe hit
- p_index_o  out  IDX_W  probe index
- r_req_i  in  1  TLBR strobe
- r_index_i  in  IDX_W  read index
- r_done_o  out  1  one-cycle pulse, read data valid
- r_vpn2_o, r_asid_o, r_g_o, r_pfn0_o, r_pfn1_o, r_c0_o, r_c1_o, r_d0_o, r_d1_o, r_v0_o, r_v1_o  out  same widths as write fields
- wired_we_i  in  1  CP0 Wired write
- wired_i  in  IDX_W  new Wired value
- random_o  out  IDX_W  current Random

## Operation
- Match rule: entry e matches when vpn2[e]==key_vpn2 && (g[e] || asid[e]==key_asid). Multiple matches (software error): lowest index wins, deterministic.
- Lookup: on inst_tlbReq_i, match computed combinationally, selected page chosen by inst_oddPage_i (0 -> pfn0/c0/d0/v0, 1 -> pfn1/...), result registered. Miss: hit=0, index=0, pfn=0, c=0, d=0, v=0.
- Outputs hold the last result while inst_tlbReq_i is low.
- Write: on w_en_i, entry at (w_random_i ? random_o : w_index_i) overwritten entirely at the clock edge.
- Probe: p_req_i registers match of the w_vpn2_i/w_asid_i key; p_done_o pulses next cycle; p_index_o=0 on miss.
- Read: r_req_i registers entry r_index_i; r_done_o pulses next cycle; r_* hold until next read.
- Random: decrements by 1 each cycle; when equal to Wired (or below it) next value is TLBNUM-1. wired_we_i forces Random to TLBNUM-1 next cycle (priority over decrement). Wired >= TLBNUM-1 keeps Random at TLBNUM-1.
- Wired register reset 0, written by wired_we_i.

## Timing
- Reset (async, rst=0): all entries cleared (v0=v1=g=0, other fields 0); all outputs 0; p_done_o=r_done_o=0; Random=TLBNUM-1; Wired=0.
- Lookup/probe/read latency: exactly 1 cycle, fully pipelined (back-to-back strobes each return next cycle).
- Write and lookup/probe/read in same cycle to same entry: the response reflects OLD contents; new contents visible from the following cycle.
- TLBWR uses Random value of the write cycle, before that cycle's decrement.
- Reset asserted mid-operation: pending probe/read pulses suppressed; no write completes.
- Probe and read may coincide with lookup; all three ports independent.

## Configuration
- TLB_RANDOM_EN: defined -> Random counter and Wired register as above. Undefined -> no counter; random_o constant TLBNUM-1; w_random_i=1 writes entry TLBNUM-1; wired_we_i ignored.

## Test plan
- Reset, then lookup vpn2=0x00001, asid=0 -> next cycle inst_hit_o=0, all lookup outputs 0.
- TLBWI index 3 {vpn2=0x12345, asid=0x05, g=0, pfn1=0xABCDE, c1=3, d1=1, v1=1}; lookup vpn2=0x12345, odd=1, asid=0x05 -> hit=1, index=3, pfn=0xABCDE, c=3, d=1, v=1; asid=0x06 -> hit=0; repeat with g=1 and asid=0x06 -> hit=1.
- Same-cycle TLBWI to index 3 with new pfn1=0x11111 and lookup of that VA -> returns 0xABCDE; following lookup returns 0x11111.
- TLBP on key present at index 7 and at index 2 (duplicate) -> p_done_o pulse, p_hit_o=1, p_index_o=2; TLBR index 7 -> r_done_o pulse, fields equal written values.
- TLB_RANDOM_EN, TLBNUM=16: after reset random_o 15,14,...; write Wired=12 -> next cycle 15, then 14,13,12,15; TLBWR when random_o=13 writes entry 13.
- rst asserted the cycle after p_req_i -> p_done_o stays 0, entries cleared, random_o=15.
